parking_multi: RTL and testbench

PARKING_MULTI -- requirements
Module: parking_multi

---
 rtl/parking_multi.sv | 154 +++++++++++++++
 tb/tb_parking_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_multi.sv
// rtl/parking_multi.sv - multi-lane parking gate occupancy counter
module parking_multi #(
  parameter int LANES    = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] enter_pulse,
  output logic [LANES-1:0] exit_pulse,
  output logic [LANES-1:0] reject,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  // E* track an a-first (entering) car, X* a b-first (leaving) car
  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} lane_state_t;

  lane_state_t      state      [LANES];
  lane_state_t      state_next [LANES];
  logic [1:0]       ab         [LANES];
  logic [LANES-1:0] entry_ev;
  logic [LANES-1:0] exit_ev;

  logic [CNT_W-1:0] occ;
  logic [LANES-1:0] enter_next;
  logic [LANES-1:0] exit_next;
  logic [LANES-1:0] reject_next;
  logic             underflow_next;

  // Pair each lane's sensors as {a,b} so the transition table reads naturally
  for (genvar g = 0; g < LANES; g++) begin : g_ab
    assign ab[g] = {a[g], b[g]};
  end

  // Per-lane sequence recogniser: next state and completed-event flags
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_next[i] = IDLE;
      entry_ev[i]   = 1'b0;
      exit_ev[i]    = 1'b0;
      case (state[i])
        IDLE: begin
          if (ab[i] == 2'b10)      state_next[i] = E1;
          else if (ab[i] == 2'b01) state_next[i] = X1;
          else                     state_next[i] = IDLE;
        end
        E1: begin
          if (ab[i] == 2'b11)      state_next[i] = E2;
          else if (ab[i] == 2'b10) state_next[i] = E1;
          else                     state_next[i] = IDLE;
        end
        E2: begin
          if (ab[i] == 2'b01)      state_next[i] = E3;
          else if (ab[i] == 2'b10) state_next[i] = E1;
          else if (ab[i] == 2'b11) state_next[i] = E2;
          else                     state_next[i] = IDLE;
        end
        E3: begin
          if (ab[i] == 2'b00) begin
            state_next[i] = IDLE;
            entry_ev[i]   = 1'b1;
          end
          else if (ab[i] == 2'b11) state_next[i] = E2;
          else if (ab[i] == 2'b01) state_next[i] = E3;
          else                     state_next[i] = IDLE;
        end
        X1: begin
          if (ab[i] == 2'b11)      state_next[i] = X2;
          else if (ab[i] == 2'b01) state_next[i] = X1;
          else                     state_next[i] = IDLE;
        end
        X2: begin
          if (ab[i] == 2'b10)      state_next[i] = X3;
          else if (ab[i] == 2'b01) state_next[i] = X1;
          else if (ab[i] == 2'b11) state_next[i] = X2;
          else                     state_next[i] = IDLE;
        end
        X3: begin
          if (ab[i] == 2'b00) begin
            state_next[i] = IDLE;
            exit_ev[i]    = 1'b1;
          end
          else if (ab[i] == 2'b11) state_next[i] = X2;
          else if (ab[i] == 2'b10) state_next[i] = X3;
          else                     state_next[i] = IDLE;
        end
        default: state_next[i] = IDLE;
      endcase
    end
  end

  // Occupancy arbitration: exits free slots first, then entries fill them in lane order
  always_comb begin
    occ            = count;
    enter_next     = '0;
    exit_next      = '0;
    reject_next    = '0;
    underflow_next = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (exit_ev[i]) begin
        if (occ != '0) begin
          occ          = occ - CNT_W'(1);
          exit_next[i] = 1'b1;
        end
        else begin
          underflow_next = 1'b1;
        end
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (entry_ev[i]) begin
        if (occ < CAP) begin
          occ           = occ + CNT_W'(1);
          enter_next[i] = 1'b1;
        end
        else begin
          reject_next[i] = 1'b1;
        end
      end
    end
  end

  // State, occupancy, flags and pulses; reset wins over any completing event
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state[i] <= IDLE;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      enter_pulse <= '0;
      exit_pulse  <= '0;
      reject      <= '0;
      underflow   <= 1'b0;
    end
    else begin
      for (int i = 0; i < LANES; i++) state[i] <= state_next[i];
      count       <= occ;
      full        <= (occ == CAP);
      empty       <= (occ == '0);
      enter_pulse <= enter_next;
      exit_pulse  <= exit_next;
      reject      <= reject_next;
      underflow   <= underflow_next;
    end
  end

endmodule

// File: tb/tb_parking_multi.sv
// tb/tb_parking_multi.sv - randomized model-checked bench for parking_multi
module tb_parking_multi;

  localparam int L   = 2;
  localparam int CW  = 8;
  localparam int CAP = 3;

  logic          clk;
  logic          reset;
  logic [L-1:0]  a;
  logic [L-1:0]  b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [L-1:0]  enter_pulse;
  logic [L-1:0]  exit_pulse;
  logic [L-1:0]  reject;
  logic          underflow;

  parking_multi #(.LANES(L), .CNT_W(CW), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .count(count), .full(full),
    .empty(empty), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .reject(reject), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_valid = 0;

  // model: per lane a direction (0 none, 1 entering, 2 leaving) and progress depth 1..3
  int mdir [L];
  int mdep [L];
  int exp_count;
  logic [L-1:0] exp_enter, exp_exit, exp_reject;
  logic exp_underflow;

  // k-th code (0..3) of the canonical entering / leaving sequence
  function automatic logic [1:0] seq_code(int dir, int k);
    logic [1:0] e [4];
    logic [1:0] x [4];
    e[0] = 2'b10; e[1] = 2'b11; e[2] = 2'b01; e[3] = 2'b00;
    x[0] = 2'b01; x[1] = 2'b11; x[2] = 2'b10; x[3] = 2'b00;
    return (dir == 1) ? e[k] : x[k];
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  task automatic model_step(logic r, logic [1:0] c [L]);
    int n;
    logic [L-1:0] ent, ext;
    ent = '0; ext = '0;
    exp_enter = '0; exp_exit = '0; exp_reject = '0; exp_underflow = 1'b0;
    if (r) begin
      for (int i = 0; i < L; i++) begin mdir[i] = 0; mdep[i] = 0; end
      exp_count = 0;
    end
    else begin
      for (int i = 0; i < L; i++) begin
        if (mdir[i] == 0) begin
          if (c[i] == 2'b10)      begin mdir[i] = 1; mdep[i] = 1; end
          else if (c[i] == 2'b01) begin mdir[i] = 2; mdep[i] = 1; end
        end
        else if (c[i] == seq_code(mdir[i], mdep[i]-1)) begin
          // holding the current pattern keeps progress
        end
        else if (mdep[i] < 3 && c[i] == seq_code(mdir[i], mdep[i])) begin
          mdep[i]++;
        end
        else if (mdep[i] > 1 && c[i] == seq_code(mdir[i], mdep[i]-2)) begin
          mdep[i]--;
        end
        else begin
          if (mdep[i] == 3 && c[i] == 2'b00) begin
            if (mdir[i] == 1) ent[i] = 1'b1; else ext[i] = 1'b1;
          end
          mdir[i] = 0; mdep[i] = 0;
        end
      end
      n = exp_count;
      for (int i = 0; i < L; i++)
        if (ext[i]) begin
          if (n > 0) begin n--; exp_exit[i] = 1'b1; end
          else exp_underflow = 1'b1;
        end
      for (int i = 0; i < L; i++)
        if (ent[i]) begin
          if (n < CAP) begin n++; exp_enter[i] = 1'b1; end
          else exp_reject[i] = 1'b1;
        end
      exp_count = n;
    end
    model_valid = 1;
  endtask

  // drive one cycle of lane codes, advance the model, return just after the edge
  task automatic step(logic r, logic [1:0] c0, logic [1:0] c1);
    logic [1:0] c [L];
    @(negedge clk);
    #1;
    c[0] = c0; c[1] = c1;
    reset = r;
    a = {c1[1], c0[1]};
    b = {c1[0], c0[0]};
    model_step(r, c);
    @(posedge clk);
    #1;
  endtask

  // compare DUT against the model every cycle, mid-period
  always @(negedge clk) begin
    if (model_valid) begin
      chk("count", 32'(count), 32'(exp_count));
      chk("full", 32'(full), 32'(exp_count == CAP));
      chk("empty", 32'(empty), 32'(exp_count == 0));
      chk("enter_pulse", 32'(enter_pulse), 32'(exp_enter));
      chk("exit_pulse", 32'(exit_pulse), 32'(exp_exit));
      chk("reject", 32'(reject), 32'(exp_reject));
      chk("underflow", 32'(underflow), 32'(exp_underflow));
    end
  end

  int sdir [L];
  int spos [L];
  logic [1:0] rc [L];

  initial begin
    reset = 1'b1; a = '0; b = '0;
    exp_count = 0; exp_enter = '0; exp_exit = '0; exp_reject = '0; exp_underflow = 1'b0;
    for (int i = 0; i < L; i++) begin mdir[i] = 0; mdep[i] = 0; sdir[i] = 0; spos[i] = 4; end

    step(1, 2'b00, 2'b00);
    step(1, 2'b00, 2'b00);
    chk("lit_reset_count", 32'(count), 0);
    chk("lit_reset_empty", 32'(empty), 1);
    chk("lit_reset_full", 32'(full), 0);
    chk("lit_reset_pulses", 32'({enter_pulse, exit_pulse, reject, underflow}), 0);

    // single entry on lane 0
    step(0, 2'b10, 2'b00); step(0, 2'b11, 2'b00); step(0, 2'b01, 2'b00);
    chk("lit_pre_entry_pulse", 32'(enter_pulse), 0);
    step(0, 2'b00, 2'b00);
    chk("lit_entry_pulse", 32'(enter_pulse), 32'b01);
    chk("lit_entry_count", 32'(count), 1);
    chk("lit_entry_empty", 32'(empty), 0);

    // aborted then completed exit on lane 1
    step(0, 2'b00, 2'b10); step(0, 2'b00, 2'b11); step(0, 2'b00, 2'b00);
    chk("lit_abort_pulses", 32'({enter_pulse, exit_pulse}), 0);
    chk("lit_abort_count", 32'(count), 1);
    step(0, 2'b00, 2'b01); step(0, 2'b00, 2'b11); step(0, 2'b00, 2'b10); step(0, 2'b00, 2'b00);
    chk("lit_exit_pulse", 32'(exit_pulse), 32'b10);
    chk("lit_exit_count", 32'(count), 0);
    chk("lit_exit_empty", 32'(empty), 1);

    // fill to capacity, fourth entry refused
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) step(0, seq_code(1, j), 2'b00);
      chk("lit_fill_count", 32'(count), 32'((k < 3) ? k + 1 : 3));
      chk("lit_fill_reject", 32'(reject), 32'((k == 3) ? 1 : 0));
    end
    chk("lit_fill_full", 32'(full), 1);

    // simultaneous exit and entry at full
    for (int j = 0; j < 4; j++) step(0, seq_code(2, j), seq_code(1, j));
    chk("lit_swap_exit", 32'(exit_pulse), 32'b01);
    chk("lit_swap_enter", 32'(enter_pulse), 32'b10);
    chk("lit_swap_reject", 32'(reject), 0);
    chk("lit_swap_count", 32'(count), 3);
    chk("lit_swap_full", 32'(full), 1);

    // drain, then double exit at zero
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) step(0, seq_code(2, j), 2'b00);
    chk("lit_drain_count", 32'(count), 0);
    for (int j = 0; j < 4; j++) step(0, seq_code(2, j), seq_code(2, j));
    chk("lit_uflow", 32'(underflow), 1);
    chk("lit_uflow_exit", 32'(exit_pulse), 0);
    chk("lit_uflow_count", 32'(count), 0);

    // reset in the middle of an entry
    step(0, 2'b10, 2'b00); step(0, 2'b11, 2'b00);
    step(1, 2'b11, 2'b00);
    step(0, 2'b01, 2'b00); step(0, 2'b00, 2'b00);
    chk("lit_rst_mid_pulse", 32'({enter_pulse, exit_pulse, reject}), 0);
    chk("lit_rst_mid_count", 32'(count), 0);

    // randomized: lanes mostly follow canonical sequences, with noise, holds and rare resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < L; i++) begin
        if (spos[i] >= 4) begin
          sdir[i] = ($urandom_range(0, 1) == 0) ? 1 : 2;
          spos[i] = 0;
        end
        case ($urandom_range(0, 9))
          0: rc[i] = 2'($urandom_range(0, 3));
          1: rc[i] = (spos[i] > 0) ? seq_code(sdir[i], spos[i]-1) : 2'b00;
          default: begin rc[i] = seq_code(sdir[i], spos[i]); spos[i]++; end
        endcase
      end
      step(($urandom_range(0, 199) == 0), rc[0], rc[1]);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
